scope_screen: RTL and testbench



---
 rtl/scope_screen.sv | 167 ++++++++++++++++
 tb/tb_scope_screen.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/scope_screen.sv
// scope_screen: parametrised raster generator with spectrum/waterfall rendering and frame-latched marker.
// Optional peak-hold trace is enabled by defining SCOPE_PEAK_EN. AMP_W must not exceed 8.
module scope_screen #(
    parameter int H_ACTIVE    = 1024,
    parameter int H_FP        = 24,
    parameter int H_SYNC      = 136,
    parameter int H_BP        = 160,
    parameter int V_ACTIVE    = 768,
    parameter int V_FP        = 3,
    parameter int V_SYNC      = 6,
    parameter int V_BP        = 29,
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0,
    parameter int SPEC_LINES  = 512,
    parameter int WF_LINES    = 256,
    parameter int AMP_W       = 8,
    parameter int SCALE_LOG2  = 1,
    parameter int ADDR_W      = 10,
    parameter int GRID_X_LOG2 = 5,
    parameter int GRID_Y      = 53
) (
    input  logic              i_pixClk,
    input  logic              i_rst,
    input  logic [AMP_W-1:0]  i_amplitude,
    input  logic [AMP_W-1:0]  i_peak,
    input  logic [AMP_W-1:0]  i_wfPixel,
    input  logic [ADDR_W-1:0] i_marker_x,
    input  logic              i_marker_en,
    output logic              o_rd,
    output logic [ADDR_W-1:0] o_addr,
    output logic [ADDR_W-1:0] o_wf_line,
    output logic              o_spectrumActive,
    output logic              o_wfActive,
    output logic              o_wf_sync,
    output logic              o_frame_start,
    output logic              o_hs,
    output logic              o_vs,
    output logic              o_de,
    output logic [7:0]        o_rgb_r,
    output logic [7:0]        o_rgb_g,
    output logic [7:0]        o_rgb_b
);
    localparam int HA0 = H_FP + H_SYNC + H_BP;
    localparam int VA0 = V_FP + V_SYNC + V_BP;
    localparam int HT  = HA0 + H_ACTIVE;
    localparam int VT  = VA0 + V_ACTIVE;
    localparam int XW  = $clog2(HT);
    localparam int YW  = $clog2(VT);
    localparam int GW  = $clog2(GRID_Y + 1);
    localparam int MW  = XW > ADDR_W ? XW : ADDR_W;

    function automatic logic [23:0] midmap(input logic [AMP_W-1:0] v);
        logic [7:0] e;
        e = 8'(v) << (8 - AMP_W);
        return {e[7] ? {e[6:0], 1'b0} : 8'h00, e, ~e};
    endfunction

    logic [XW-1:0] h_q, h_d, x, x1_q;
    logic [YW-1:0] v_q, v_d, y, y1_q;
    logic [GW-1:0] gm_q, gm_d;
    logic h_wrap, active, spec, wf, hs_raw, vs_raw, fs_raw;
    logic act1_q, spec1_q, wf1_q, gy1_q, hs1_q, vs1_q, fs1_q;
    logic hs_q, vs_q, de_q, fs_q, mk_en_q;
    logic [ADDR_W-1:0] mk_x_q;
    logic [23:0] rgb_q, rgb_d, spec_rgb;
    logic [AMP_W-1:0] lvl;
    logic grid, mk_hit;

    assign h_wrap = h_q == XW'(HT - 1);
    // grid row counter restarts on the first active line, so no divider is needed
    always_comb begin
        h_d  = h_wrap ? '0 : h_q + 1'b1;
        v_d  = !h_wrap ? v_q : (v_q == YW'(VT - 1) ? '0 : v_q + 1'b1);
        gm_d = !h_wrap ? gm_q : (v_d == YW'(VA0) || gm_q == GW'(GRID_Y - 1)) ? '0 : gm_q + 1'b1;
    end

    assign active = h_q >= XW'(HA0) && v_q >= YW'(VA0);
    assign x      = h_q - XW'(HA0);
    assign y      = v_q - YW'(VA0);
    assign spec   = active && y < YW'(SPEC_LINES);
    assign wf     = active && !spec && y < YW'(SPEC_LINES + WF_LINES);
    assign hs_raw = (h_q >= XW'(H_FP) && h_q < XW'(H_FP + H_SYNC)) ? HS_POL : !HS_POL;
    assign vs_raw = (v_q >= YW'(V_FP) && v_q < YW'(V_FP + V_SYNC)) ? VS_POL : !VS_POL;
    assign fs_raw = h_q == '0 && v_q == YW'(V_FP);

    assign o_rd             = spec || wf;
    assign o_addr           = active ? ADDR_W'(x) : '0;
    assign o_wf_line        = wf ? ADDR_W'(y - YW'(SPEC_LINES)) : '0;
    assign o_spectrumActive = spec;
    assign o_wfActive       = wf;
    assign o_wf_sync        = spec && x == '0 && y == YW'(SPEC_LINES - 1);

`ifdef SCOPE_PEAK_EN
    logic pk_hit;
`else
    logic unused_peak;
    assign unused_peak = ^i_peak;
`endif

    always_comb begin
        lvl  = AMP_W'((YW'(SPEC_LINES - 1) - y1_q) >> SCALE_LOG2);
        grid = x1_q[GRID_X_LOG2-1:0] == '0 || gy1_q;
`ifdef SCOPE_PEAK_EN
        pk_hit   = i_peak == lvl;
        spec_rgb = {pk_hit ? 8'hFF : 8'h00,
                    i_amplitude >= lvl ? 16'(midmap(i_amplitude)) : pk_hit ? 16'(midmap(i_peak)) : 16'h0};
`else
        spec_rgb = {8'h00, i_amplitude >= lvl ? 16'(midmap(i_amplitude)) : 16'h0};
`endif
        spec_rgb[7] = spec_rgb[7] | grid;
        mk_hit = act1_q && mk_en_q && MW'(x1_q) == MW'(mk_x_q);
        rgb_d  = mk_hit ? 24'hFFFFFF : spec1_q ? spec_rgb : wf1_q ? midmap(i_wfPixel) : 24'h0;
    end

    always_ff @(posedge i_pixClk or posedge i_rst) begin
        if (i_rst) begin
            h_q     <= '0;
            v_q     <= '0;
            gm_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            act1_q  <= 1'b0;
            spec1_q <= 1'b0;
            wf1_q   <= 1'b0;
            gy1_q   <= 1'b0;
            hs1_q   <= !HS_POL;
            vs1_q   <= !VS_POL;
            fs1_q   <= 1'b0;
            hs_q    <= !HS_POL;
            vs_q    <= !VS_POL;
            de_q    <= 1'b0;
            fs_q    <= 1'b0;
            rgb_q   <= '0;
            mk_en_q <= 1'b0;
            mk_x_q  <= '0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            gm_q    <= gm_d;
            x1_q    <= x;
            y1_q    <= y;
            act1_q  <= active;
            spec1_q <= spec;
            wf1_q   <= wf;
            gy1_q   <= gm_q == '0;
            hs1_q   <= hs_raw;
            vs1_q   <= vs_raw;
            fs1_q   <= fs_raw;
            hs_q    <= hs1_q;
            vs_q    <= vs1_q;
            de_q    <= act1_q;
            fs_q    <= fs1_q;
            rgb_q   <= rgb_d;
            // marker only changes at frame start so the cursor never tears
            if (fs_q) begin
                mk_en_q <= i_marker_en;
                mk_x_q  <= i_marker_x;
            end
        end
    end

    assign o_hs          = hs_q;
    assign o_vs          = vs_q;
    assign o_de          = de_q;
    assign o_frame_start = fs_q;
    assign {o_rgb_r, o_rgb_g, o_rgb_b} = rgb_q;
endmodule

// File: tb/tb_scope_screen.sv
// tb_scope_screen: scoreboard bench for scope_screen on a small raster (48x27 total, 40x22 active).
module tb_scope_screen;
    localparam int HFP = 2, HSY = 3, HA0 = 8, HT = 48;
    localparam int VFP = 1, VSY = 2, VA0 = 5, VT = 27;
    localparam int SL = 16, WL = 4;

    typedef struct {
        logic [27:0] p;
        int          x;
    } ent_t;

    logic       clk = 1'b0, rst = 1'b1;
    logic [2:0] amp = '0, pk = '0, wfp = '0;
    logic [4:0] mkx = 5'd3;
    logic       mken = 1'b1;
    logic       o_rd, o_spectrumActive, o_wfActive, o_wf_sync, o_frame_start, o_hs, o_vs, o_de;
    logic [4:0] o_addr, o_wf_line;
    logic [7:0] o_rgb_r, o_rgb_g, o_rgb_b;

    int   total = 0, bad = 0, hm = 0, vm = 0, frm = 0, fcount = 0, nsync = 0, mk_x_m = 0;
    bit   started = 0;
    logic mk_en_m = 1'b0;
    ent_t q[$];

    scope_screen #(
        .H_ACTIVE(40), .H_FP(HFP), .H_SYNC(HSY), .H_BP(3),
        .V_ACTIVE(22), .V_FP(VFP), .V_SYNC(VSY), .V_BP(2),
        .HS_POL(1'b0), .VS_POL(1'b0), .SPEC_LINES(SL), .WF_LINES(WL),
        .AMP_W(3), .SCALE_LOG2(1), .ADDR_W(5), .GRID_X_LOG2(3), .GRID_Y(5)
    ) dut (
        .i_pixClk(clk), .i_rst(rst), .i_amplitude(amp), .i_peak(pk), .i_wfPixel(wfp),
        .i_marker_x(mkx), .i_marker_en(mken), .o_rd(o_rd), .o_addr(o_addr), .o_wf_line(o_wf_line),
        .o_spectrumActive(o_spectrumActive), .o_wfActive(o_wfActive), .o_wf_sync(o_wf_sync),
        .o_frame_start(o_frame_start), .o_hs(o_hs), .o_vs(o_vs), .o_de(o_de),
        .o_rgb_r(o_rgb_r), .o_rgb_g(o_rgb_g), .o_rgb_b(o_rgb_b)
    );

    always #5 clk = ~clk;

    function automatic int af(input int a);
        return (a * 3 + frm) & 7;
    endfunction

    function automatic logic [23:0] mm(input logic [2:0] v);
        logic [7:0] e;
        e = {v, 5'b0};
        return {e[7] ? {e[6:0], 1'b0} : 8'h00, e, ~e};
    endfunction

    // synchronous sample RAMs: data valid one cycle after the address
    always @(posedge clk) begin
        amp <= 3'(af(int'(o_addr)));
        pk  <= 3'((int'(o_addr) >> 2) & 7);
        wfp <= 3'((int'(o_addr) + int'(o_wf_line) * 5) & 7);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s h=%0d v=%0d got=%h exp=%h", tag, hm, vm, got, exp);
        end
    endtask

    task automatic rst_chk();
        chk("rst", {o_hs, o_vs, o_de, o_rd, o_frame_start, o_wf_sync, o_spectrumActive, o_wfActive,
                    o_addr, o_wf_line, o_rgb_r, o_rgb_g, o_rgb_b}, {2'b11, 6'b0, 10'b0, 24'h0});
    endtask

    task automatic restart();
        ent_t e;
        q.delete();
        e.p = {2'b11, 2'b00, 24'h0};
        e.x = -1;
        q.push_back(e);
        q.push_back(e);
        hm = 0;
        vm = 0;
        mk_en_m = 1'b0;
        mk_x_m = 0;
        nsync = 0;
        started = 0;
    endtask

    task automatic cyc();
        int x, y, lvl, a, pv;
        bit act, spec, wf;
        logic [23:0] rgb, m;
        logic [27:0] p;
        ent_t e;
        if (hm == 0 && vm == 0) begin
            if (started) chk("wfsync_n", 64'(nsync), 64'd1);
            started = 1;
            nsync = 0;
            frm++;
            fcount++;
        end
        if (hm == 0 && vm == 10) begin
            if (fcount == 1) mkx = 5'd7;
            if (fcount == 2) mken = 1'b0;
            if (fcount == 3) begin
                mken = 1'b1;
                mkx = 5'd31;
            end
        end
        act  = hm >= HA0 && vm >= VA0;
        x    = hm - HA0;
        y    = vm - VA0;
        spec = act && y < SL;
        wf   = act && y >= SL && y < SL + WL;
        chk("fetch", {o_rd, o_spectrumActive, o_wfActive, o_wf_sync, o_addr, o_wf_line},
            {spec | wf, spec, wf, spec && x == 0 && y == SL - 1, act ? 5'(x) : 5'd0, wf ? 5'(y - SL) : 5'd0});
        nsync += int'(o_wf_sync);
        rgb = 24'h0;
        if (spec) begin
            lvl = (SL - 1 - y) >> 1;
            a   = af(x % 32);
            m   = mm(3'(a));
            if (a >= lvl) rgb[15:0] = m[15:0];
            pv  = ((x % 32) >> 2) & 7;
`ifdef SCOPE_PEAK_EN
            if (pv == lvl) begin
                rgb[23:16] = 8'hFF;
                m = mm(3'(pv));
                if (a < lvl) rgb[15:0] = m[15:0];
            end
`endif
            if (x % 8 == 0 || y % 5 == 0) rgb[7] = 1'b1;
        end else if (wf) begin
            rgb = mm(3'(((x % 32) + (y - SL) * 5) & 7));
        end
        e.p = {!(hm >= HFP && hm < HFP + HSY), !(vm >= VFP && vm < VFP + VSY), act, hm == 0 && vm == VFP, rgb};
        e.x = act ? x : -1;
        q.push_back(e);
        e = q.pop_front();
        p = e.p;
        if (p[25] && mk_en_m && e.x == mk_x_m) p[23:0] = 24'hFFFFFF;
        chk("pix", {o_hs, o_vs, o_de, o_frame_start, o_rgb_r, o_rgb_g, o_rgb_b}, p);
        if (p[24]) begin
            mk_en_m = mken;
            mk_x_m = int'(mkx);
        end
        hm = (hm == HT - 1) ? 0 : hm + 1;
        if (hm == 0) vm = (vm == VT - 1) ? 0 : vm + 1;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_chk();
        rst = 1'b0;
        restart();
        while (fcount < 4 || vm < 12) cyc();
        rst = 1'b1;
        #1;
        rst_chk();
        @(negedge clk);
        rst = 1'b0;
        restart();
        repeat (HT * VT + 50) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
